// File: rtl/modulo_pkg.sv
// modulo_pkg: shared state encoding and parameter limits for the serial modulo engine.
`default_nettype none

package modulo_pkg;

  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 32;
  localparam int MODULUS_MIN = 2;
  localparam int MODULUS_MAX = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/modulo_step.sv
// modulo_step: one restoring-division step, rem_out = (2*rem_in + bit_in) mod MODULUS.
`default_nettype none

module modulo_step #(
  parameter int MODULUS = 3,
  parameter int REM_W   = $clog2(MODULUS)
) (
  input  logic [REM_W-1:0] rem_in,
  input  logic             bit_in,
  output logic [REM_W-1:0] rem_out,
  output logic             q_bit
);

  localparam logic [REM_W:0] MOD_EXT = (REM_W+1)'(MODULUS);

  logic [REM_W:0] t;
  logic [REM_W:0] diff;

  // rem_in < MODULUS, so t < 2*MODULUS and one subtraction always suffices
  assign t       = {rem_in, bit_in};
  assign diff    = t - MOD_EXT;
  assign q_bit   = (t >= MOD_EXT);
  assign rem_out = q_bit ? diff[REM_W-1:0] : t[REM_W-1:0];

endmodule

`default_nettype wire

// File: rtl/modulo_n_serial.sv
// modulo_n_serial: MSB-first bit-serial remainder/quotient engine with valid/ready on both sides.
`default_nettype none

module modulo_n_serial
  import modulo_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 3,
  parameter int REM_W   = $clog2(MODULUS),
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [REM_W-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             divisible
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      MODULUS < MODULUS_MIN || MODULUS > MODULUS_MAX) begin : g_param_check
    $error("modulo_n_serial: WIDTH or MODULUS out of range");
  end

  state_t             state;
  state_t             state_nx;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   quot_run;
  logic [REM_W-1:0]   rem_run;
  logic [CNT_W-1:0]   cnt;
  logic [REM_W-1:0]   rem_q;
  logic [WIDTH-1:0]   quot_q;
  logic               have_q;
  logic [REM_W-1:0]   step_rem;
  logic               step_q;
  logic               accept;
  logic               last_bit;

  assign accept   = (state == ST_IDLE) && in_valid;
  assign last_bit = (state == ST_RUN) && (cnt == CNT_W'(1));

  modulo_step #(
    .MODULUS (MODULUS),
    .REM_W   (REM_W)
  ) u_step (
    .rem_in  (rem_run),
    .bit_in  (shreg[WIDTH-1]),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CNT_W'(1)) state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      quot_run <= '0;
      rem_run  <= '0;
      cnt      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      have_q   <= 1'b0;
    end else if (accept) begin
      shreg    <= in_data;
      quot_run <= '0;
      rem_run  <= '0;
      cnt      <= CNT_W'(WIDTH);
    end else if (state == ST_RUN) begin
      shreg    <= {shreg[WIDTH-2:0], 1'b0};
      quot_run <= {quot_run[WIDTH-2:0], step_q};
      rem_run  <= step_rem;
      cnt      <= cnt - CNT_W'(1);
      // Published results change only here and persist through IDLE
      if (last_bit) begin
        rem_q  <= step_rem;
        quot_q <= {quot_run[WIDTH-2:0], step_q};
        have_q <= 1'b1;
      end
    end
  end

  assign remainder = rem_q;
  assign quotient  = quot_q;
  assign divisible = have_q && (rem_q == '0);

endmodule

`default_nettype wire

// File: doc/modulo_n_serial.md
Name: modulo_n_serial

Overview:
- Parametrised bit-serial divisibility and remainder engine; the next generation of the team's modulo-3 checker.
- Accepts a WIDTH-bit unsigned operand through a valid/ready handshake and processes it MSB-first, one bit per clock, against a compile-time MODULUS.
- Returns remainder, quotient and a divisible flag through an output valid/ready handshake.
- Sits between an operand source (bench stimulus or upstream datapath) and any consumer of divisibility results.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.
- MODULUS, 3, divisor; legal range 2..255.
- REM_W, $clog2(MODULUS), remainder width (derived; do not override).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand present.
- in_data  input  WIDTH  unsigned operand.
- in_ready  output  1  block can accept an operand.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- remainder  output  REM_W  in_data mod MODULUS.
- quotient  output  WIDTH  in_data div MODULUS.
- divisible  output  1  1 when remainder == 0.

Behaviour:
- Reset is asynchronous and active-high on a single clock, clk. Asserting rst forces, immediately:
  - state IDLE, in_ready=1, out_valid=0;
  - remainder=0, quotient=0, divisible=0;
  - internal shift register and counter cleared.
- FSM states:
  - IDLE: in_ready=1. On in_valid && in_ready at an edge: capture in_data into the shift register, clear the running remainder and quotient, load counter=WIDTH, go to RUN.
  - RUN: in_ready=0. Each cycle, take bit b = MSB of the shift register.
    - t = 2*rem + b, computed in REM_W+1 bits.
    - If t >= MODULUS: rem <= t - MODULUS and shift quotient left with a 1.
    - Otherwise: rem <= t and shift quotient left with a 0.
    - Shift the operand left and decrement the counter.
    - When the counter reaches 1 at an edge, the last bit is consumed: go to DONE.
  - DONE: out_valid=1. remainder, quotient and divisible hold stable. On out_ready: go to IDLE, out_valid=0.
- Latency:
  - Accept edge is N. out_valid rises after edge N+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: accept, WIDTH run cycles, one DONE cycle with out_ready=1, then IDLE.
- Output timing:
  - Result outputs are registered and only update on the RUN→DONE edge.
  - Outputs keep the last result through IDLE until the next DONE.
  - divisible is combinationally derived from the registered remainder.
- Invariant: rem < MODULUS at every edge, so no wrap or overflow occurs. The quotient fits in WIDTH bits by construction.
- Boundaries:
  - in_valid while not in IDLE is ignored. The operand must be held by the source (standard valid/ready).
  - out_ready held high in DONE: exactly one transfer, then IDLE.
  - out_ready low: DONE is held indefinitely with outputs stable.
  - Operand 0: remainder 0, quotient 0, divisible 1.
  - Operand < MODULUS: remainder = operand, quotient 0.
  - rst asserted mid-RUN or in DONE: the operation is aborted and the result is discarded. No out_valid is produced for the aborted operand.
  - in_valid asserted in the same cycle rst deasserts: accepted on the first clean edge after release.

Decomposition:
- Package modulo_pkg holds:
  - the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the parameter legality limits (WIDTH_MIN, WIDTH_MAX, MODULUS_MIN, MODULUS_MAX).
- One natural combinational sub-module: modulo_step.
  - Parameter MODULUS.
  - Inputs: rem_in, bit_in.
  - Outputs: rem_out, q_bit.
  - Reusable for a future unrolled or parallel variant.
- Top level holds the FSM, counter, shift registers and handshake.

Test Plan:
- WIDTH=8, MODULUS=3; operands 0, 6, 7, 45, 96, 100, 255 with out_ready=1 → (rem,quot,div) respectively:
  - 0 → (0,0,1)
  - 6 → (0,2,1)
  - 7 → (1,2,0)
  - 45 → (0,15,1)
  - 96 → (0,32,1)
  - 100 → (1,33,0)
  - 255 → (0,85,1)
  - out_valid rises exactly 8 cycles after each accept.
- WIDTH=8, MODULUS=7; operand 255 → rem 3, quot 36, div 0. Operand 5 → rem 5, quot 0.
- WIDTH=12, MODULUS=5; operand 4095 → rem 0, quot 819, div 1. Operand 4094 → rem 4, quot 818.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, a second in_valid is not accepted. Release → one transfer, then in_ready=1.
- Reset mid-run: accept 100, assert rst after 4 RUN cycles → in_ready=1, out_valid=0 and all outputs 0 immediately. Next operand 45 → rem 0, quot 15.
- Back-to-back issue: continuous in_valid and out_ready → accepts spaced exactly WIDTH+2 cycles apart, with no result lost or duplicated.
